pe_requant: RTL and testbench
=============================

Name: pe_requant

Overview:
- Consumes the sign-extended 2*DATA_WIDTH-per-lane sum vectors produced by the PE adder stage.
- Narrows each lane back to DATA_WIDTH through an arithmetic right shift, round-half-up, optional ReLU and signed saturation.
- Returns packed DATA_WIDTH lanes toward the PE data buffers.
- Two-stage valid/ready pipeline with full throughput, backpressure, and a per-beat saturation counter for debug.

Parameters:
- DATA_WIDTH, 8, output lane width; input lane width is 2*DATA_WIDTH.
- DATA_COPIES, 32, number of lanes.
- SHIFT_WIDTH, 4, width of the shift-amount field.
- CNT_WIDTH, 16, width of the saturation counter.

Ports:
- i_clk  input  1  clock; all state on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_sum_data  input  DATA_COPIES*2*DATA_WIDTH  packed signed lane sums; lane i at [2*DATA_WIDTH*i +: 2*DATA_WIDTH].
- i_sum_vld  input  1  input beat valid.
- o_sum_rdy  output  1  block can accept a beat this cycle.
- i_shift  input  SHIFT_WIDTH  right-shift amount, sampled with each accepted beat.
- i_relu_en  input  1  clamp negatives to 0, sampled with each accepted beat.
- o_qdata  output  DATA_COPIES*DATA_WIDTH  packed signed results; lane i at [DATA_WIDTH*i +: DATA_WIDTH].
- o_qdata_vld  output  1  output beat valid.
- i_qdata_rdy  input  1  downstream accepts the output beat.
- i_sat_clr  input  1  clear the saturation counter.
- o_sat_cnt  output  CNT_WIDTH  count of delivered beats with at least one saturated lane.

Behaviour:
- Reset (i_rst high at a clock edge) clears:
  - s1_vld, s2_vld, o_qdata_vld, o_sat_cnt to 0.
  - o_qdata to 0.
  - Any beats in flight are dropped.
- o_sum_rdy is combinational: high when stage 1 is empty or stage 1 advances this cycle. It is low while i_rst is high.
- Handshake rules:
  - A beat transfers when vld && rdy, on both the input and output interfaces.
  - Once o_qdata_vld is high, o_qdata is held stable until i_qdata_rdy.
- Stage 1 (captured on input accept):
  - eff_shift = min(i_shift, 2*DATA_WIDTH-1).
  - Each lane is sign-extended to 2*DATA_WIDTH+1 bits.
  - If eff_shift>0, add 1<<(eff_shift-1).
  - Arithmetic right shift by eff_shift.
  - Register the result with i_relu_en.
- Stage 2 (captured when stage 1 advances):
  - If relu, negative values become 0.
  - Values above 2^(DATA_WIDTH-1)-1 become that maximum, and the lane's sat flag is set.
  - Values below -2^(DATA_WIDTH-1) become that minimum, and the lane's sat flag is set.
  - A ReLU clamp alone does not set the sat flag.
  - beat_sat = OR of the lane sat flags.
- Advance rules:
  - Stage 2 advances when !s2_vld or i_qdata_rdy.
  - Stage 1 advances when s1_vld and stage 2 advances.
  - Input is accepted into stage 1 when the stage is empty or being vacated.
- Timing:
  - Latency is 2 cycles from input accept to o_qdata_vld, with no stall.
  - Throughput is 1 beat per cycle under continuous ready.
  - Bubbles collapse: an empty stage 2 accepts stage 1 even while i_qdata_rdy is low.
- Backpressure: with i_qdata_rdy low, at most 2 beats are held. o_sum_rdy then drops and no data is lost or duplicated.
- Saturation counter:
  - o_sat_cnt increments on an output transfer whose beat_sat is set.
  - It saturates at all-ones (no wrap).
  - i_sat_clr has priority: the counter becomes 0 even if an increment coincides.
- Shift and ReLU settings travel with their beat. Changing i_shift between beats affects only subsequent accepted beats.
- Arithmetic uses 2*DATA_WIDTH+1 bits internally so the rounding add never overflows (e.g. 0x7FFF + rounding).

Decomposition:
- Shared package (npu_pkg):
  - Lane-width constants: DATA_WIDTH, 2*DATA_WIDTH.
  - Q_MAX/Q_MIN saturation bounds.
  - SHIFT_MAX = 2*DATA_WIDTH-1.
- One natural sub-module, pe_requant_lane: the combinational per-lane round/shift and relu/saturate functions, instantiated DATA_COPIES times in a generate loop.
- The top level holds the valid/ready pipeline registers and the counter.

Test Plan:
- Rounding: lane0=0x0013 (19), shift=2, relu=0, i_qdata_rdy=1 -> o_qdata lane0=5 exactly 2 cycles after accept; lane1=0xFFED (-19) -> -5 (0xFB); shift=0 passes 0x0045 -> 0x45.
- Saturation: lane0=0x0200, lane1=0xFE00, shift=0 -> lane0=0x7F, lane1=0x80; o_sat_cnt 0->1 on output transfer; a second identical beat with i_sat_clr high in the same transfer cycle -> o_sat_cnt=0.
- ReLU: lane0=0xFFF0, relu=1 -> 0x00, no sat increment; lane0=0x0300, relu=1 -> 0x7F, sat increment.
- Backpressure:
  - Stimulus: continuous i_sum_vld with beats numbered 1..10 in lane0; i_qdata_rdy low for cycles 4-9, then high.
  - Response: o_sum_rdy low once 2 beats are held; outputs 1..10 appear in order with no gaps once ready, no loss or duplicates; o_qdata stable while stalled.
- Throughput and boundaries:
  - 100 random beats with ready always high -> 1 output per cycle, matching the golden model.
  - i_shift=15 with 0x7FFF -> 1 (round up, no overflow).
  - i_shift=15 with 0x8000 -> -1.
- Reset mid-operation: assert i_rst for 1 cycle with 2 beats in flight -> o_qdata_vld=0 and o_sat_cnt=0 next cycle, o_sum_rdy high after release, held beats never emitted.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU lane constants: lane widths, saturation bounds and shift limits
// used by the PE requantisation stage and anything else narrowing PE sums.
package npu_pkg;

    localparam int DATA_WIDTH  = 8;
    localparam int SUM_WIDTH   = 2 * DATA_WIDTH;
    localparam int DATA_COPIES = 32;
    localparam int SHIFT_WIDTH = 4;
    localparam int CNT_WIDTH   = 16;

    // Largest shift that still leaves the sign bit of a sum lane in range.
    localparam int SHIFT_MAX = SUM_WIDTH - 1;

    // Signed bounds of a lane of the given width.
    function automatic int q_max(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    function automatic int q_min(input int width);
        return -(1 << (width - 1));
    endfunction

    localparam int Q_MAX = q_max(DATA_WIDTH);
    localparam int Q_MIN = q_min(DATA_WIDTH);

endpackage

// File: rtl/pe_requant_lane.sv
// Per-lane requantisation datapath, purely combinational.
// Front half (feeds stage 1): sign-extend, round-half-up, arithmetic shift.
// Back half (feeds stage 2): optional ReLU then signed saturation.
module pe_requant_lane
    import npu_pkg::*;
#(
    parameter int DATA_WIDTH  = npu_pkg::DATA_WIDTH,
    parameter int SHIFT_WIDTH = npu_pkg::SHIFT_WIDTH
) (
    input  logic [2*DATA_WIDTH-1:0]      sum,
    input  logic [SHIFT_WIDTH-1:0]       shift,
    output logic signed [2*DATA_WIDTH:0] shifted,
    input  logic signed [2*DATA_WIDTH:0] s1_val,
    input  logic                         relu,
    output logic [DATA_WIDTH-1:0]        q,
    output logic                         sat
);

    localparam int SUM_W     = 2 * DATA_WIDTH;
    // One guard bit so the rounding add cannot overflow (e.g. 0x7FFF + half).
    localparam int EXT_W     = SUM_W + 1;
    localparam int SHIFT_LIM = SUM_W - 1;

    localparam logic signed [EXT_W-1:0] HI = EXT_W'(q_max(DATA_WIDTH));
    localparam logic signed [EXT_W-1:0] LO = EXT_W'(q_min(DATA_WIDTH));

    logic [SHIFT_WIDTH-1:0]  eff_shift;
    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] rnd_inc;
    logic signed [EXT_W-1:0] rnd_sum;
    logic signed [EXT_W-1:0] relu_val;

    // Round half up at the shift position, then arithmetic shift right.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would otherwise infer a latch.
        eff_shift = shift;
        rnd_inc   = '0;
        if (int'(shift) > SHIFT_LIM) begin
            eff_shift = SHIFT_WIDTH'(SHIFT_LIM);
        end
        ext = {sum[SUM_W-1], sum};
        if (eff_shift != '0) begin
            rnd_inc = EXT_W'(1) << (eff_shift - 1'b1);
        end
        rnd_sum = ext + rnd_inc;
        shifted = rnd_sum >>> eff_shift;
    end

    // ReLU clamp first, then saturate; only the saturation sets the flag.
    always_comb begin
        relu_val = s1_val;
        if (relu && s1_val[EXT_W-1]) begin
            relu_val = '0;
        end
        q   = relu_val[DATA_WIDTH-1:0];
        sat = 1'b0;
        if (relu_val > HI) begin
            q   = HI[DATA_WIDTH-1:0];
            sat = 1'b1;
        end else if (relu_val < LO) begin
            q   = LO[DATA_WIDTH-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/pe_requant.sv
// PE requantisation: narrows 2*DATA_WIDTH lane sums to DATA_WIDTH lanes via a
// two-stage valid/ready pipeline (shift+round, then ReLU+saturate) and
// counts delivered beats that saturated in at least one lane.
module pe_requant
    import npu_pkg::*;
#(
    parameter int DATA_WIDTH  = npu_pkg::DATA_WIDTH,
    parameter int DATA_COPIES = npu_pkg::DATA_COPIES,
    parameter int SHIFT_WIDTH = npu_pkg::SHIFT_WIDTH,
    parameter int CNT_WIDTH   = npu_pkg::CNT_WIDTH
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic [DATA_COPIES*2*DATA_WIDTH-1:0] i_sum_data,
    input  logic                                i_sum_vld,
    output logic                                o_sum_rdy,
    input  logic [SHIFT_WIDTH-1:0]              i_shift,
    input  logic                                i_relu_en,
    output logic [DATA_COPIES*DATA_WIDTH-1:0]   o_qdata,
    output logic                                o_qdata_vld,
    input  logic                                i_qdata_rdy,
    input  logic                                i_sat_clr,
    output logic [CNT_WIDTH-1:0]                o_sat_cnt
);

    localparam int SUM_W = 2 * DATA_WIDTH;
    localparam int EXT_W = SUM_W + 1;

    // Stage 1: shifted/rounded lanes plus the ReLU setting of that beat.
    logic                            s1_vld;
    logic                            s1_relu;
    logic [DATA_COPIES*EXT_W-1:0]    s1_val;
    logic [DATA_COPIES*EXT_W-1:0]    s1_next;

    // Stage 2 is the output register itself (o_qdata / o_qdata_vld).
    logic                            s2_sat;
    logic [DATA_COPIES*DATA_WIDTH-1:0] q_next;
    logic [DATA_COPIES-1:0]          lane_sat;

    logic s2_adv;
    logic s1_adv;
    logic in_acc;
    logic out_xfer;

    // An empty output register takes stage 1 even under backpressure.
    assign s2_adv    = !o_qdata_vld || i_qdata_rdy;
    assign s1_adv    = s1_vld && s2_adv;
    assign o_sum_rdy = !i_rst && (!s1_vld || s2_adv);
    assign in_acc    = i_sum_vld && o_sum_rdy;
    assign out_xfer  = o_qdata_vld && i_qdata_rdy;

    for (genvar g = 0; g < DATA_COPIES; g++) begin : g_lane
        pe_requant_lane #(
            .DATA_WIDTH  (DATA_WIDTH),
            .SHIFT_WIDTH (SHIFT_WIDTH)
        ) u_lane (
            .sum     (i_sum_data[SUM_W*g +: SUM_W]),
            .shift   (i_shift),
            .shifted (s1_next[EXT_W*g +: EXT_W]),
            .s1_val  (s1_val[EXT_W*g +: EXT_W]),
            .relu    (s1_relu),
            .q       (q_next[DATA_WIDTH*g +: DATA_WIDTH]),
            .sat     (lane_sat[g])
        );
    end

    // Stage 1 occupancy: filled on accept, emptied when it moves to stage 2.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (i_rst) begin
            s1_vld <= 1'b0;
        end else if (in_acc) begin
            s1_vld <= 1'b1;
        end else if (s1_adv) begin
            s1_vld <= 1'b0;
        end
    end

    // Stage 1 payload; shift and ReLU settings travel with the beat.
    always_ff @(posedge i_clk) begin
        // NOTE: payload registers are qualified by s1_vld, so they carry no
        // reset and stay plain enable flops.
        if (in_acc) begin
            s1_val  <= s1_next;
            s1_relu <= i_relu_en;
        end
    end

    // Stage 2 / output register, held stable while stalled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_qdata_vld <= 1'b0;
            o_qdata     <= '0;
            s2_sat      <= 1'b0;
        end else if (s2_adv) begin
            o_qdata_vld <= s1_vld;
            if (s1_vld) begin
                o_qdata <= q_next;
                s2_sat  <= |lane_sat;
            end
        end
    end

    // Saturating debug counter of delivered beats that clipped; clear wins.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_sat_clr) begin
            o_sat_cnt <= '0;
        end else if (out_xfer && s2_sat && (o_sat_cnt != '1)) begin
            o_sat_cnt <= o_sat_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pe_requant.sv
// Directed bench for pe_requant: table of single-beat vectors with
// hand-computed results, then saturation-clear, backpressure, random
// throughput against a reference model, boundary shifts and mid-run reset.
module tb_pe_requant;

    logic         i_clk;
    logic         i_rst;
    logic [511:0] i_sum_data;
    logic         i_sum_vld;
    logic         o_sum_rdy;
    logic [3:0]   i_shift;
    logic         i_relu_en;
    logic [255:0] o_qdata;
    logic         o_qdata_vld;
    logic         i_qdata_rdy;
    logic         i_sat_clr;
    logic [15:0]  o_sat_cnt;

    pe_requant dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_sum_data  (i_sum_data),
        .i_sum_vld   (i_sum_vld),
        .o_sum_rdy   (o_sum_rdy),
        .i_shift     (i_shift),
        .i_relu_en   (i_relu_en),
        .o_qdata     (o_qdata),
        .o_qdata_vld (o_qdata_vld),
        .i_qdata_rdy (i_qdata_rdy),
        .i_sat_clr   (i_sat_clr),
        .o_sat_cnt   (o_sat_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [15:0] l0;
        logic [15:0] l1;
        int          sh;
        bit          relu;
        logic [7:0]  e0;
        logic [7:0]  e1;
        bit          sat;
    } vec_t;

    typedef struct {
        logic [255:0] d;
        bit           sat;
    } exp_t;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [15:0] cnt_exp;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] pack2(input logic [15:0] a, input logic [15:0] b);
        logic [511:0] r;
        r        = '0;
        r[15:0]  = a;
        r[31:16] = b;
        return r;
    endfunction

    // Reference lane: exact integer arithmetic in 64 bits.
    function automatic logic [7:0] ref_lane(input logic [15:0] s, input int sh,
                                            input bit relu, output bit sat);
        longint v;
        int     e;
        v = longint'(signed'(s));
        e = (sh > 15) ? 15 : sh;
        if (e > 0) v = v + (longint'(1) << (e - 1));
        v = v >>> e;
        if (relu && v < 0) v = 0;
        sat = 1'b0;
        if (v > 127) begin
            v   = 127;
            sat = 1'b1;
        end else if (v < -128) begin
            v   = -128;
            sat = 1'b1;
        end
        return v[7:0];
    endfunction

    // One beat through an idle pipeline with ready high; checks latency,
    // lanes, and the counter before and after the output transfer.
    task automatic run_one(input vec_t v, input bit clr, input string tag);
        @(negedge i_clk);
        i_sum_data  = pack2(v.l0, v.l1);
        i_shift     = 4'(v.sh);
        i_relu_en   = v.relu;
        i_sum_vld   = 1'b1;
        i_qdata_rdy = 1'b1;
        #1 check({tag, "_in_rdy"}, o_sum_rdy, 1);
        @(negedge i_clk);
        i_sum_vld = 1'b0;
        check({tag, "_vld_c1"}, o_qdata_vld, 0);
        @(negedge i_clk);
        check({tag, "_vld_c2"}, o_qdata_vld, 1);
        check({tag, "_lane0"}, o_qdata[7:0], v.e0);
        check({tag, "_lane1"}, o_qdata[15:8], v.e1);
        check({tag, "_rest"}, o_qdata[255:16], 0);
        check({tag, "_cnt_pre"}, o_sat_cnt, cnt_exp);
        i_sat_clr = clr;
        if (clr) cnt_exp = 0;
        else if (v.sat && cnt_exp != 16'hFFFF) cnt_exp = cnt_exp + 1'b1;
        @(negedge i_clk);
        i_sat_clr = 1'b0;
        check({tag, "_sat_cnt"}, o_sat_cnt, cnt_exp);
        check({tag, "_vld_after"}, o_qdata_vld, 0);
    endtask

    vec_t vecs[11];
    vec_t satv;
    exp_t sb[$];
    exp_t e;

    int           sent, got, first_out, last_out;
    int           acc_n, del_n, nb;
    bit           prev_stall, ls;
    logic [255:0] prev_q;

    initial begin
        vecs[0]  = '{16'h0013, 16'hFFED, 2,  1'b0, 8'h05, 8'hFB, 1'b0};
        vecs[1]  = '{16'h0045, 16'h0000, 0,  1'b0, 8'h45, 8'h00, 1'b0};
        vecs[2]  = '{16'h0200, 16'hFE00, 0,  1'b0, 8'h7F, 8'h80, 1'b1};
        vecs[3]  = '{16'hFFF0, 16'h0000, 0,  1'b1, 8'h00, 8'h00, 1'b0};
        vecs[4]  = '{16'h0300, 16'h0000, 0,  1'b1, 8'h7F, 8'h00, 1'b1};
        vecs[5]  = '{16'h7FFF, 16'h8000, 15, 1'b0, 8'h01, 8'hFF, 1'b0};
        vecs[6]  = '{16'h0006, 16'hFFFA, 2,  1'b0, 8'h02, 8'hFF, 1'b0};
        vecs[7]  = '{16'h0080, 16'hFF7F, 0,  1'b0, 8'h7F, 8'h80, 1'b1};
        vecs[8]  = '{16'h0100, 16'hFF00, 1,  1'b0, 8'h7F, 8'h80, 1'b1};
        vecs[9]  = '{16'h007F, 16'hFF80, 0,  1'b0, 8'h7F, 8'h80, 1'b0};
        vecs[10] = '{16'hFF80, 16'h0081, 0,  1'b1, 8'h00, 8'h7F, 1'b1};
        satv     = '{16'h0200, 16'h0000, 0,  1'b0, 8'h7F, 8'h00, 1'b1};

        i_rst       = 1'b1;
        i_sum_data  = '0;
        i_sum_vld   = 1'b0;
        i_shift     = '0;
        i_relu_en   = 1'b0;
        i_qdata_rdy = 1'b1;
        i_sat_clr   = 1'b0;
        cnt_exp     = '0;

        // Reset state.
        repeat (2) @(negedge i_clk);
        check("rst_qdata_vld", o_qdata_vld, 0);
        check("rst_qdata", o_qdata, 0);
        check("rst_sat_cnt", o_sat_cnt, 0);
        check("rst_in_rdy_low", o_sum_rdy, 0);
        i_rst = 1'b0;
        #1 check("rst_in_rdy_rel", o_sum_rdy, 1);

        // Table-driven single beats.
        for (int i = 0; i < 11; i++) run_one(vecs[i], 1'b0, $sformatf("vec%0d", i));

        // Clear, count one saturated beat, then clear coinciding with a transfer.
        @(negedge i_clk);
        i_sat_clr = 1'b1;
        @(negedge i_clk);
        i_sat_clr = 1'b0;
        cnt_exp   = '0;
        check("clr_cnt", o_sat_cnt, 0);
        run_one(satv, 1'b0, "sat_inc");
        run_one(satv, 1'b1, "sat_clr");

        // Backpressure: beats 1..10 back to back, ready low in cycles 4..9.
        acc_n = 0; del_n = 0; nb = 1; prev_stall = 1'b0; prev_q = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge i_clk);
            if (prev_stall) begin
                check("bp_hold_vld", o_qdata_vld, 1);
                check("bp_hold_data", o_qdata, prev_q);
            end
            i_qdata_rdy = !(cyc >= 4 && cyc <= 9);
            i_sum_vld   = (nb <= 10);
            i_sum_data  = pack2(16'(nb), 16'h0000);
            i_shift     = '0;
            i_relu_en   = 1'b0;
            #1;
            check("bp_held_le2", (acc_n - del_n) <= 2, 1);
            if ((acc_n - del_n) == 2 && !i_qdata_rdy) check("bp_in_rdy_low", o_sum_rdy, 0);
            if (cyc >= 10 && del_n < 10) check("bp_no_gap", o_qdata_vld, 1);
            if (o_qdata_vld && i_qdata_rdy) begin
                check("bp_order", o_qdata, 256'(del_n + 1));
                del_n++;
            end
            if (i_sum_vld && o_sum_rdy) begin
                acc_n++;
                nb++;
            end
            prev_stall = o_qdata_vld && !i_qdata_rdy;
            prev_q     = o_qdata;
        end
        i_sum_vld   = 1'b0;
        i_qdata_rdy = 1'b1;
        check("bp_delivered", del_n, 10);
        check("bp_accepted", acc_n, 10);

        // Random throughput against the reference model, ready always high.
        sent = 0; got = 0; first_out = -1; last_out = -1;
        for (int cyc = 0; cyc < 130; cyc++) begin
            @(negedge i_clk);
            i_qdata_rdy = 1'b1;
            if (sent < 100) begin
                for (int l = 0; l < 32; l++) i_sum_data[16*l +: 16] = 16'($urandom);
                i_shift   = 4'($urandom_range(0, 15));
                i_relu_en = 1'($urandom_range(0, 1));
                i_sum_vld = 1'b1;
            end else begin
                i_sum_vld = 1'b0;
            end
            #1;
            if (sent < 100) check("tp_in_rdy", o_sum_rdy, 1);
            if (o_qdata_vld) begin
                if (sb.size() == 0) begin
                    check("tp_spurious_vld", o_qdata_vld, 0);
                end else begin
                    e = sb.pop_front();
                    check("tp_data", o_qdata, e.d);
                    if (e.sat && cnt_exp != 16'hFFFF) cnt_exp = cnt_exp + 1'b1;
                    got++;
                    if (first_out < 0) first_out = cyc;
                    last_out = cyc;
                end
            end
            if (i_sum_vld && o_sum_rdy) begin
                e.sat = 1'b0;
                for (int l = 0; l < 32; l++) begin
                    e.d[8*l +: 8] = ref_lane(i_sum_data[16*l +: 16], int'(i_shift), i_relu_en, ls);
                    e.sat = e.sat | ls;
                end
                sb.push_back(e);
                sent++;
            end
        end
        i_sum_vld = 1'b0;
        check("tp_count", got, 100);
        check("tp_no_gaps", 32'(last_out - first_out), 99);
        check("tp_sat_cnt", o_sat_cnt, cnt_exp);

        // Reset with two beats held under backpressure.
        @(negedge i_clk);
        i_qdata_rdy = 1'b0;
        i_sum_data  = pack2(16'h0200, 16'h0000);
        i_shift     = '0;
        i_relu_en   = 1'b0;
        i_sum_vld   = 1'b1;
        @(negedge i_clk);
        i_sum_data = pack2(16'h0300, 16'h0000);
        @(negedge i_clk);
        i_sum_vld = 1'b0;
        #1;
        check("mr_full_rdy_low", o_sum_rdy, 0);
        check("mr_held_vld", o_qdata_vld, 1);
        check("mr_cnt_pre", o_sat_cnt, cnt_exp);
        i_rst = 1'b1;
        #1 check("mr_rdy_in_rst", o_sum_rdy, 0);
        @(negedge i_clk);
        i_rst       = 1'b0;
        i_qdata_rdy = 1'b1;
        cnt_exp     = '0;
        check("mr_vld_cleared", o_qdata_vld, 0);
        check("mr_cnt_cleared", o_sat_cnt, 0);
        check("mr_qdata_cleared", o_qdata, 0);
        #1 check("mr_rdy_after", o_sum_rdy, 1);
        repeat (4) begin
            @(negedge i_clk);
            check("mr_no_ghost", o_qdata_vld, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Run-time bound in case the pipeline wedges.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
